// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement a - b - bin, LSB first, with start/busy/done handshake
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic br_q, br_d, bout_q, bout_d, zero_q, zero_d;
    logic d_bit, br_next;
    logic [WIDTH-1:0] shifted;
    assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign shifted = {d_bit, r_q[WIDTH-1:1]};
    // next-state: capture in IDLE, one full-subtractor step per cycle in RUN, publish result on the last bit
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a;
                b_d     = b;
                br_d    = bin;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = shifted;
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = shifted;
                    bout_d  = br_next;
                    zero_d  = (shifted == '0);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor against an arithmetic reference model
module tb_serial_subtractor;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst, start, bin, busy, done, bout, zero;
    logic [W-1:0] a, b, diff, last_diff;
    logic [W:0] exp_q[$];
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    endfunction
    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        logic [W:0] e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got diff %0h with no operation outstanding", diff);
            end else begin
                e = exp_q.pop_front();
                chk("diff", {24'd0, diff}, {23'd0, 1'b0, e[W-1:0]});
                chk("bout", {31'd0, bout}, {31'd0, e[W]});
                chk("zero", {31'd0, zero}, {31'd0, e[W-1:0] == '0});
            end
        end
    end
    // one operation issued from IDLE; returns one cycle after done, back in IDLE
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int n;
        logic [W:0] r;
        r = model(x, y, c);
        a = x; b = y; bin = c; start = 1'b1;
        exp_q.push_back(r);
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        n = 0;
        while (busy && n < 20) begin
            chk("diff_hold", {24'd0, diff}, {24'd0, last_diff});
            n++;
            @(posedge clk); #1;
        end
        chk("busy_len", n, 8);
        chk("done_pulse", {31'd0, done}, 1);
        last_diff = r[W-1:0];
        @(posedge clk); #1;
        chk("done_len", {31'd0, done}, 0);
    endtask
    initial begin
        int rises[$];
        int n;
        logic pb;
        logic [W:0] r;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_diff", {24'd0, diff}, 0);
        chk("rst_bout", {31'd0, bout}, 0);
        chk("rst_zero", {31'd0, zero}, 0);
        last_diff = '0;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_busy", {31'd0, busy}, 0);
            chk("idle_done", {31'd0, done}, 0);
        end
        run_op(8'd5, 8'd3, 1'b0);
        run_op(8'd3, 8'd5, 1'b0);
        run_op(8'd0, 8'd0, 1'b1);
        run_op(8'h80, 8'h80, 1'b0);
        // start held high: acceptances every WIDTH+2 cycles
        a = 8'h9C; b = 8'h27; bin = 1'b1; start = 1'b1;
        pb = busy;
        for (int cyc = 0; cyc < 40 && rises.size() < 3; cyc++) begin
            @(posedge clk); #1;
            if (busy && !pb) begin
                rises.push_back(cyc);
                exp_q.push_back(model(a, b, bin));
            end
            pb = busy;
        end
        start = 1'b0;
        chk("held_accepts", rises.size(), 3);
        if (rises.size() == 3) begin
            chk("held_gap1", rises[1] - rises[0], 10);
            chk("held_gap2", rises[2] - rises[1], 10);
        end
        n = 0;
        while (!done && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk("held_done", {31'd0, done}, 1);
        r = model(8'h9C, 8'h27, 1'b1);
        last_diff = r[W-1:0];
        @(posedge clk); #1;
        // reset during RUN bit 4 discards the operation
        a = 8'h12; b = 8'h34; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_done", {31'd0, done}, 0);
        chk("midrst_diff", {24'd0, diff}, 0);
        chk("midrst_bout", {31'd0, bout}, 0);
        chk("midrst_zero", {31'd0, zero}, 0);
        last_diff = '0;
        repeat (12) begin
            @(posedge clk); #1;
            chk("midrst_no_done", {31'd0, done}, 0);
        end
        run_op(8'hFF, 8'h01, 1'b0);
        for (int i = 0; i < 1000; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom));
        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
